// File: rtl/dmem_port.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port
// Brief    : Byte-addressed big-endian MIPS data memory with a valid/ready
//            request port, RD_LAT-deep load pipeline and in-order response
//            FIFO. Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port #(
    parameter int MEMSIZE = 1024,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_AW = $clog2(MEMSIZE);
    localparam int c_CW = $clog2(RD_LAT + 1);
    localparam int c_PW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int c_FD = 1 << c_PW;

    localparam logic [c_CW-1:0] c_LAT      = c_CW'(RD_LAT);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW:0]   c_FCNT_ONE = (c_PW + 1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_AW-1:0] c_A1       = c_AW'(1);
    localparam logic [c_AW-1:0] c_A2       = c_AW'(2);
    localparam logic [c_AW-1:0] c_A3       = c_AW'(3);
    localparam logic [32:0]     c_MEMEND   = 33'(MEMSIZE);

    logic [7:0]      r_mem [MEMSIZE];
    logic [c_CW-1:0] r_count;

    logic            w_acc;
    logic            w_hand;
    logic            w_err;
    logic            w_misalign;
    logic [2:0]      w_nbytes;
    logic [32:0]     w_end;
    logic [c_AW-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0]      w_b0, w_b1, w_b2, w_b3;
    logic [31:0]     w_ld_data;
    logic [31:0]     w_pin_data;

    logic            w_ins_vld;
    logic            w_ins_err;
    logic [31:0]     w_ins_data;

    logic [31:0]     r_fdata [c_FD];
    logic            r_ferr  [c_FD];
    logic [c_PW-1:0] r_wp;
    logic [c_PW-1:0] r_rp;
    logic [c_PW:0]   r_fcnt;

    assign w_acc     = req_valid & req_ready;
    assign w_hand    = rsp_valid & rsp_ready;
    // Ready depends only on credit state and the response side, never req_valid
    assign req_ready = (r_count < c_LAT) | ((r_count == c_LAT) & w_hand);

    // Bounds are evaluated in 33 bits so addresses near 2^32 cannot wrap
    always_comb begin
        w_nbytes = 3'd1;
        case (req_size)
            2'b01:   w_nbytes = 3'd2;
            2'b10:   w_nbytes = 3'd4;
            default: w_nbytes = 3'd1;
        endcase
    end

    assign w_end = {1'b0, req_addr} + {30'd0, w_nbytes};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'b01) & req_addr[0]) |
                        ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (req_size == 2'b11) | (w_end > c_MEMEND) | w_misalign;

    assign w_a0 = req_addr[c_AW-1:0];
    assign w_a1 = w_a0 + c_A1;
    assign w_a2 = w_a0 + c_A2;
    assign w_a3 = w_a0 + c_A3;
    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_ld_data = '0;
        if (!w_err) begin
            case (req_size)
                2'b00:   w_ld_data = {{24{req_signed & w_b0[7]}}, w_b0};
                2'b01:   w_ld_data = {{16{req_signed & w_b0[7]}}, w_b0, w_b1};
                2'b10:   w_ld_data = {w_b0, w_b1, w_b2, w_b3};
                default: w_ld_data = '0;
            endcase
        end
    end

    assign w_pin_data = req_we ? '0 : w_ld_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEMSIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_acc && req_we && !w_err) begin
            case (req_size)
                2'b00: r_mem[w_a0] <= req_wdata[7:0];
                2'b01: begin
                    r_mem[w_a0] <= req_wdata[15:8];
                    r_mem[w_a1] <= req_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_a0] <= req_wdata[31:24];
                    r_mem[w_a1] <= req_wdata[23:16];
                    r_mem[w_a2] <= req_wdata[15:8];
                    r_mem[w_a3] <= req_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_acc, w_hand})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The accept edge itself is the first latency stage; RD_LAT-1 more follow
    generate
        if (RD_LAT == 1) begin : g_direct
            assign w_ins_vld  = w_acc;
            assign w_ins_err  = w_err;
            assign w_ins_data = w_pin_data;
        end else begin : g_pipe
            localparam int c_STG = RD_LAT - 1;
            logic [c_STG-1:0] r_pv;
            logic [c_STG-1:0] r_pe;
            logic [31:0]      r_pd [c_STG];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pv <= '0;
                    r_pe <= '0;
                    for (int i = 0; i < c_STG; i++) begin
                        r_pd[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_acc;
                    r_pe[0] <= w_err;
                    r_pd[0] <= w_pin_data;
                    for (int i = 1; i < c_STG; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pe[i] <= r_pe[i-1];
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end

            assign w_ins_vld  = r_pv[c_STG-1];
            assign w_ins_err  = r_pe[c_STG-1];
            assign w_ins_data = r_pd[c_STG-1];
        end
    endgenerate

    // Credit limit keeps occupancy <= RD_LAT, so the FIFO cannot overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < c_FD; i++) begin
                r_fdata[i] <= '0;
                r_ferr[i]  <= 1'b0;
            end
        end else begin
            if (w_ins_vld) begin
                r_fdata[r_wp] <= w_ins_data;
                r_ferr[r_wp]  <= w_ins_err;
                r_wp          <= r_wp + c_PTR_ONE;
            end
            if (w_hand) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            case ({w_ins_vld, w_hand})
                2'b10:   r_fcnt <= r_fcnt + c_FCNT_ONE;
                2'b01:   r_fcnt <= r_fcnt - c_FCNT_ONE;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign rsp_valid = (r_fcnt != '0);
    assign rsp_rdata = rsp_valid ? r_fdata[r_rp] : '0;
    assign rsp_err   = rsp_valid & r_ferr[r_rp];

endmodule
`default_nettype wire
